// File: rtl/fm_mon_receiver.sv
// Fast-monitor stream receiver: frames contiguous valid words, buffers them in an eof-tagged FIFO
// and exposes a read-enable drain port plus frame/drop/truncation statistics.
module fm_mon_receiver #(
    parameter int unsigned DEPTH         = 64,
    parameter int unsigned MAX_FRAME_LEN = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [32:0]                mon_data,
    input  logic                       rd_en,
    output logic [32:0]                rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           trunc_cnt,
    input  logic                       clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned LW = $clog2(MAX_FRAME_LEN) + 1;
    localparam int unsigned DW = 32;
    localparam int unsigned EW = DW + 1;

    typedef enum logic [1:0] {
        SYNC     = 2'd0,
        IDLE     = 2'd1,
        IN_FRAME = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   hold_q;
    logic [LW-1:0]   wcnt_q;
    logic [LW-1:0]   wcnt_nxt;
    logic            load_hold;
    logic            wr_en;
    logic            wr_eof;
    logic            inc_frame;
    logic            inc_trunc;
    logic            inc_drop;
    logic            word_valid;
    logic            has_space;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            rd_fire;
    logic [FW-1:0]   fill_nxt;

    assign word_valid = mon_data[32];
    // No FIFO write is ever pending while in IDLE, so current occupancy is the admission basis.
    assign has_space  = (FW'(DEPTH) - fill) >= FW'(MAX_FRAME_LEN);
    assign rd_fire    = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SYNC;
            hold_q <= '0;
            wcnt_q <= '0;
        end else begin
            state  <= state_nxt;
            wcnt_q <= wcnt_nxt;
            if (load_hold) begin
                hold_q <= mon_data[DW-1:0];
            end
        end
    end

    // Frame FSM: the held word is written one edge late, once its eof status is known.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt_q;
        load_hold = 1'b0;
        wr_en     = 1'b0;
        wr_eof    = 1'b0;
        inc_frame = 1'b0;
        inc_trunc = 1'b0;
        inc_drop  = 1'b0;
        case (state)
            SYNC: begin
                if (!word_valid) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (word_valid) begin
                    if (has_space) begin
                        load_hold = 1'b1;
                        wcnt_nxt  = LW'(1);
                        state_nxt = IN_FRAME;
                    end else begin
                        inc_drop  = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            IN_FRAME: begin
                if (!word_valid) begin
                    wr_en     = 1'b1;
                    wr_eof    = 1'b1;
                    inc_frame = 1'b1;
                    state_nxt = IDLE;
                end else if (wcnt_q < LW'(MAX_FRAME_LEN)) begin
                    wr_en     = 1'b1;
                    load_hold = 1'b1;
                    wcnt_nxt  = wcnt_q + LW'(1);
                end else begin
                    wr_en     = 1'b1;
                    wr_eof    = 1'b1;
                    inc_frame = 1'b1;
                    inc_trunc = 1'b1;
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (!word_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Storage array carries no reset; validity is defined by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {wr_eof, hold_q};
        end
    end

    always_comb begin
        fill_nxt = fill + FW'(wr_en) - FW'(rd_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            fill     <= fill_nxt;
            empty    <= (fill_nxt == '0);
            full     <= (fill_nxt == FW'(DEPTH));
            rd_valid <= rd_fire;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
        end
    end

    // Saturating statistics counter; a coincident clear takes priority over the increment.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic             inc,
                                                  input logic             clr);
        logic [CNT_W-1:0] res;
        res = cur;
        if (clr) begin
            res = '0;
        end else if (inc && (cur != '1)) begin
            res = cur + CNT_W'(1);
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            frame_cnt <= cnt_next(frame_cnt, inc_frame, clear);
            drop_cnt  <= cnt_next(drop_cnt, inc_drop, clear);
            trunc_cnt <= cnt_next(trunc_cnt, inc_trunc, clear);
        end
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: tb/tb_fm_mon_receiver.sv
// Self-checking bench for fm_mon_receiver: directed scenarios plus randomized traffic against a
// queue-based frame model.
module tb_fm_mon_receiver;

    localparam int DEPTH = 64;
    localparam int MAXL  = 16;

    logic        clk;
    logic        rst;
    logic [32:0] mon_data;
    logic        rd_en;
    logic        clear;
    logic [32:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [6:0]  fill;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] trunc_cnt;

    int tests = 0;
    int fails = 0;

    fm_mon_receiver #(.DEPTH(DEPTH), .MAX_FRAME_LEN(MAXL), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .mon_data (mon_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .fill     (fill),
        .frame_cnt(frame_cnt),
        .drop_cnt (drop_cnt),
        .trunc_cnt(trunc_cnt),
        .clear    (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stored entries as a queue, plus the frame in progress.
    logic [32:0] mq[$];
    bit          m_sync;
    bit          m_inf;
    bit          m_drop;
    int          m_n;
    logic [31:0] m_hold;
    int          m_frame;
    int          m_dropc;
    int          m_trunc;
    logic [32:0] e_rd_data;
    bit          e_rd_valid;

    function automatic int sat(input int c);
        return (c < 65535) ? c + 1 : c;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_sync     = 1'b1;
        m_inf      = 1'b0;
        m_drop     = 1'b0;
        m_n        = 0;
        m_hold     = '0;
        m_frame    = 0;
        m_dropc    = 0;
        m_trunc    = 0;
        e_rd_data  = '0;
        e_rd_valid = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d, input bit re, input bit clr);
        int sz;
        sz = mq.size();
        e_rd_valid = 1'b0;
        if (re && sz > 0) begin
            e_rd_data  = mq.pop_front();
            e_rd_valid = 1'b1;
        end
        if (m_sync) begin
            if (!v) m_sync = 1'b0;
        end else if (m_drop) begin
            if (!v) m_drop = 1'b0;
        end else if (!m_inf) begin
            if (v) begin
                if (DEPTH - sz >= MAXL) begin
                    m_inf  = 1'b1;
                    m_hold = d;
                    m_n    = 1;
                end else begin
                    m_drop  = 1'b1;
                    m_dropc = sat(m_dropc);
                end
            end
        end else begin
            if (!v) begin
                mq.push_back({1'b1, m_hold});
                m_frame = sat(m_frame);
                m_inf   = 1'b0;
            end else if (m_n < MAXL) begin
                mq.push_back({1'b0, m_hold});
                m_hold = d;
                m_n++;
            end else begin
                mq.push_back({1'b1, m_hold});
                m_frame = sat(m_frame);
                m_trunc = sat(m_trunc);
                m_inf   = 1'b0;
                m_drop  = 1'b1;
            end
        end
        if (clr) begin
            m_frame = 0;
            m_dropc = 0;
            m_trunc = 0;
        end
    endtask

    // One clock of stimulus; the model advances with the edge and outputs are sampled 1 time unit later.
    task automatic step(input bit v, input logic [31:0] d, input bit re, input bit clr);
        mon_data = {v, d};
        rd_en    = re;
        clear    = clr;
        @(posedge clk);
        model_edge(v, d, re, clr);
        #1;
    endtask

    task automatic send_frame(input int len);
        for (int i = 0; i < len; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        mon_data = '0;
        rd_en    = 1'b0;
        clear    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({fill, empty, full, rd_valid} !== {7'd0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_flags: got fill=%0d empty=%b full=%b rd_valid=%b, want 0 1 0 0",
                     fill, empty, full, rd_valid);
        end
        tests++;
        if ({rd_data, frame_cnt, drop_cnt, trunc_cnt} !== 81'd0) begin
            fails++;
            $display("FAIL reset_regs: got rd_data=%h cnts=%0d/%0d/%0d, want all zero",
                     rd_data, frame_cnt, drop_cnt, trunc_cnt);
        end
    endtask

    task automatic test_basic_frame();
        logic [32:0] want [3];
        want[0] = {1'b0, 32'h00C0FFEE};
        want[1] = {1'b0, 32'h000FEED5};
        want[2] = {1'b1, 32'h0BEECAFE};
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h00C0FFEE, 1'b0, 1'b0);
        step(1'b1, 32'h000FEED5, 1'b0, 1'b0);
        step(1'b1, 32'h0BEECAFE, 1'b0, 1'b0);
        tests++;
        if (fill !== 7'd2) begin
            fails++;
            $display("FAIL basic_fill_latency: got %0d want 2", fill);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (fill !== 7'd3 || frame_cnt !== 16'd1 || empty !== 1'b0) begin
            fails++;
            $display("FAIL basic_after_frame: got fill=%0d frame_cnt=%0d empty=%b want 3 1 0",
                     fill, frame_cnt, empty);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== want[i] || rd_data !== e_rd_data) begin
                fails++;
                $display("FAIL basic_read%0d: got v=%b data=%h want v=1 data=%h", i, rd_valid, rd_data, want[i]);
            end
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== want[2] || empty !== 1'b1) begin
            fails++;
            $display("FAIL basic_read_empty: got v=%b data=%h empty=%b want v=0 data=%h empty=1",
                     rd_valid, rd_data, empty, want[2]);
        end
    endtask

    task automatic test_reset_mid_burst();
        rst      = 1'b1;
        model_reset();
        mon_data = {1'b1, 32'hAAAA0001};
        rd_en    = 1'b0;
        clear    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA0003, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (fill !== 7'd0 || frame_cnt !== 16'd0) begin
            fails++;
            $display("FAIL sync_partial: got fill=%0d frame_cnt=%0d want 0 0", fill, frame_cnt);
        end
        send_frame(3);
        tests++;
        if (fill !== 7'd3 || fill !== 7'(mq.size()) || frame_cnt !== 16'd1) begin
            fails++;
            $display("FAIL sync_next_frame: got fill=%0d frame_cnt=%0d want 3 1", fill, frame_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            tests++;
            if (rd_valid !== e_rd_valid || rd_data !== e_rd_data) begin
                fails++;
                $display("FAIL sync_read%0d: got v=%b data=%h want v=%b data=%h",
                         i, rd_valid, rd_data, e_rd_valid, e_rd_data);
            end
        end
    endtask

    task automatic test_truncation();
        int t0;
        int f0;
        t0 = int'(trunc_cnt);
        f0 = int'(frame_cnt);
        send_frame(20);
        tests++;
        if (fill !== 7'd16 || int'(trunc_cnt) !== t0 + 1 || int'(frame_cnt) !== f0 + 1) begin
            fails++;
            $display("FAIL trunc_counts: got fill=%0d trunc=%0d frame=%0d want 16 %0d %0d",
                     fill, trunc_cnt, frame_cnt, t0 + 1, f0 + 1);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== e_rd_data || rd_data[32] !== (i == 15)) begin
                fails++;
                $display("FAIL trunc_read%0d: got v=%b data=%h want v=1 data=%h",
                         i, rd_valid, rd_data, e_rd_data);
            end
        end
    endtask

    task automatic test_drop();
        int d0;
        int f0;
        int guard;
        for (int k = 0; k < 5; k++) send_frame(10);
        tests++;
        if (fill !== 7'd50) begin
            fails++;
            $display("FAIL drop_prefill: got fill=%0d want 50", fill);
        end
        d0 = int'(drop_cnt);
        f0 = int'(frame_cnt);
        send_frame(5);
        tests++;
        if (fill !== 7'd50 || int'(drop_cnt) !== d0 + 1 || int'(frame_cnt) !== f0) begin
            fails++;
            $display("FAIL drop_reject: got fill=%0d drop=%0d frame=%0d want 50 %0d %0d",
                     fill, drop_cnt, frame_cnt, d0 + 1, f0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        send_frame(3);
        tests++;
        if (fill !== 7'd51 || int'(frame_cnt) !== f0 + 1 || int'(drop_cnt) !== d0 + 1) begin
            fails++;
            $display("FAIL drop_accept_at_48: got fill=%0d frame=%0d want 51 %0d", fill, frame_cnt, f0 + 1);
        end
        guard = 0;
        while (mq.size() > 0 && guard < 200) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            guard++;
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== e_rd_data) begin
                fails++;
                $display("FAIL drop_drain: got v=%b data=%h want v=1 data=%h", rd_valid, rd_data, e_rd_data);
            end
        end
        tests++;
        if (empty !== 1'b1 || fill !== 7'd0) begin
            fails++;
            $display("FAIL drop_drained: got empty=%b fill=%0d want 1 0", empty, fill);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            step((c % 5) != 4, $urandom, 1'b1, 1'b0);
            tests++;
            if (fill !== 7'(mq.size()) || rd_valid !== e_rd_valid || rd_data !== e_rd_data) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got fill=%0d v=%b data=%h want fill=%0d v=%b data=%h",
                         c, fill, rd_valid, rd_data, mq.size(), e_rd_valid, e_rd_data);
            end
        end
        for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        tests++;
        if (rd_valid !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL b2b_read_empty: got v=%b empty=%b want 0 1", rd_valid, empty);
        end
    endtask

    task automatic test_clear();
        step(1'b1, 32'h11111111, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        tests++;
        if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0 || trunc_cnt !== 16'd0 || fill !== 7'd2) begin
            fails++;
            $display("FAIL clear_vs_eof: got frame=%0d drop=%0d trunc=%0d fill=%0d want 0 0 0 2",
                     frame_cnt, drop_cnt, trunc_cnt, fill);
        end
        send_frame(4);
        tests++;
        if (frame_cnt !== 16'd1 || fill !== 7'd6) begin
            fails++;
            $display("FAIL clear_next_frame: got frame=%0d fill=%0d want 1 6", frame_cnt, fill);
        end
    endtask

    task automatic test_random();
        int rem;
        bit v;
        rem = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rem > 0) begin
                v = 1'b1;
                rem--;
            end else begin
                v = 1'b0;
                if ($urandom_range(0, 2) == 0) rem = $urandom_range(1, 22);
            end
            step(v, $urandom, ($urandom_range(0, 9) < 4), ($urandom_range(0, 199) == 0));
            tests++;
            if (fill !== 7'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                fails++;
                $display("FAIL rand_fill c%0d: got fill=%0d empty=%b full=%b want fill=%0d",
                         c, fill, empty, full, mq.size());
            end
            tests++;
            if (rd_valid !== e_rd_valid || rd_data !== e_rd_data) begin
                fails++;
                $display("FAIL rand_read c%0d: got v=%b data=%h want v=%b data=%h",
                         c, rd_valid, rd_data, e_rd_valid, e_rd_data);
            end
            tests++;
            if (frame_cnt !== 16'(m_frame) || drop_cnt !== 16'(m_dropc) || trunc_cnt !== 16'(m_trunc)) begin
                fails++;
                $display("FAIL rand_cnt c%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         c, frame_cnt, drop_cnt, trunc_cnt, m_frame, m_dropc, m_trunc);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        mon_data = '0;
        rd_en    = 1'b0;
        clear    = 1'b0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_reset_mid_burst();
        test_truncation();
        test_drop();
        test_back_to_back();
        test_clear();
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
